// File: rtl/rdseed_buffer.sv
// Seed store between the conditioner and the host RDSEED port: buffers whole
// seeds and hands them out one word per request, zeroizing each word as it leaves.
module rdseed_buffer #(
  parameter int SEED_WIDTH = 256,
  parameter int WORD_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       seed_valid_i,
  output logic                       seed_ready_o,
  input  logic [SEED_WIDTH-1:0]      seed_i,
  input  logic                       req_i,
  input  logic                       flush_i,
  output logic                       rsp_valid_o,
  output logic                       rsp_ok_o,
  output logic [WORD_WIDTH-1:0]      rsp_data_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int SLICES  = SEED_WIDTH / WORD_WIDTH;
  localparam int SLICE_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [SLICE_W-1:0]    slice_reg;
  logic                  rsp_valid_reg;
  logic                  rsp_ok_reg;
  logic [WORD_WIDTH-1:0] rsp_data_reg;

  logic [WORD_WIDTH-1:0] word_arr [DEPTH][SLICES];
  logic [WORD_WIDTH-1:0] head_word;
  logic                  push;
  logic                  pop;
  logic                  pop_last;

  // Flush blocks acceptance so a seed offered during a flush is never lost silently.
  assign seed_ready_o = (count_reg < CNT_W'(DEPTH)) && !flush_i;
  assign push         = seed_valid_i && seed_ready_o;
  assign pop          = req_i && !flush_i && (count_reg != '0);
  assign pop_last     = pop && (slice_reg == SLICE_W'(SLICES - 1));
  assign head_word    = word_arr[rd_ptr_reg][slice_reg];

  // Storage is word-granular so each served word can be wiped on its own;
  // async reset clears it too, hence plain registers rather than block RAM.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      for (genvar gj = 0; gj < SLICES; gj++) begin : g_slice
        logic [WORD_WIDTH-1:0] word_reg;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            word_reg <= '0;
          end else if (flush_i) begin
            word_reg <= '0;
          end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
            word_reg <= seed_i[gj*WORD_WIDTH +: WORD_WIDTH];
          end else if (pop && (rd_ptr_reg == PTR_W'(gi)) && (slice_reg == SLICE_W'(gj))) begin
            word_reg <= '0;
          end
        end

        assign word_arr[gi][gj] = word_reg;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      slice_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_ok_reg    <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      rsp_valid_reg <= req_i;
      rsp_ok_reg    <= pop;
      rsp_data_reg  <= pop ? head_word : '0;

      if (flush_i) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
        slice_reg  <= '0;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
          if (pop_last) begin
            slice_reg  <= '0;
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          end else begin
            slice_reg <= slice_reg + SLICE_W'(1);
          end
        end
        case ({push, pop_last})
          2'b10:   count_reg <= count_reg + CNT_W'(1);
          2'b01:   count_reg <= count_reg - CNT_W'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_ok_o    = rsp_ok_reg;
  assign rsp_data_o  = rsp_data_reg;
  assign level_o     = count_reg;

endmodule

// File: tb/tb_rdseed_buffer.sv
// Scoreboard bench for rdseed_buffer: a word-stream model predicts every
// response, a negedge monitor compares responses, level and ready.
module tb_rdseed_buffer;

  localparam int SEED_WIDTH = 256;
  localparam int WORD_WIDTH = 64;
  localparam int DEPTH      = 4;
  localparam int SLICES     = SEED_WIDTH / WORD_WIDTH;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic                          seed_valid_i = 1'b0;
  logic                          seed_ready_o;
  logic [SEED_WIDTH-1:0]         seed_i = '0;
  logic                          req_i = 1'b0;
  logic                          flush_i = 1'b0;
  logic                          rsp_valid_o;
  logic                          rsp_ok_o;
  logic [WORD_WIDTH-1:0]         rsp_data_o;
  logic [$clog2(DEPTH):0]        level_o;

  int checks = 0;
  int errors = 0;

  // Model: stored entropy is just the ordered stream of words still unread.
  logic [WORD_WIDTH-1:0] words[$];
  logic [WORD_WIDTH:0]   exp_q[$];

  always #5 clk = ~clk;

  rdseed_buffer #(.SEED_WIDTH(SEED_WIDTH), .WORD_WIDTH(WORD_WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .seed_valid_i (seed_valid_i),
    .seed_ready_o (seed_ready_o),
    .seed_i       (seed_i),
    .req_i        (req_i),
    .flush_i      (flush_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ok_o     (rsp_ok_o),
    .rsp_data_o   (rsp_data_o),
    .level_o      (level_o)
  );

  function automatic int model_level();
    return (words.size() + SLICES - 1) / SLICES;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      words.delete();
      exp_q.delete();
    end else begin
      automatic bit accept = (model_level() < DEPTH) && !flush_i;
      if (req_i) begin
        if (!flush_i && words.size() > 0) exp_q.push_back({1'b1, words.pop_front()});
        else exp_q.push_back({1'b0, {WORD_WIDTH{1'b0}}});
      end
      if (flush_i) words.delete();
      else if (seed_valid_i && accept)
        for (int j = 0; j < SLICES; j++) words.push_back(seed_i[j*WORD_WIDTH +: WORD_WIDTH]);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid", 64'(rsp_valid_o), 64'd0);
      check("rst_ok", 64'(rsp_ok_o), 64'd0);
      check("rst_data", rsp_data_o, 64'd0);
      check("rst_level", 64'(level_o), 64'd0);
      check("rst_ready", 64'(seed_ready_o), 64'd1);
    end else begin
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
        end else begin
          automatic logic [WORD_WIDTH:0] e = exp_q.pop_front();
          $display("rsp ok=%0d data=%h (exp ok=%0d data=%h) level=%0d",
                   rsp_ok_o, rsp_data_o, e[WORD_WIDTH], e[WORD_WIDTH-1:0], level_o);
          check("rsp_ok", 64'(rsp_ok_o), 64'(e[WORD_WIDTH]));
          check("rsp_data", rsp_data_o, e[WORD_WIDTH-1:0]);
        end
      end else begin
        check("idle_ok", 64'(rsp_ok_o), 64'd0);
        check("idle_data", rsp_data_o, 64'd0);
      end
      check("level", 64'(level_o), 64'(model_level()));
      check("ready", 64'(seed_ready_o), 64'((model_level() < DEPTH) && !flush_i));
    end
  end

  task automatic cycle(input bit v, input logic [SEED_WIDTH-1:0] s, input bit r, input bit f);
    seed_valid_i = v;
    seed_i       = s;
    req_i        = r;
    flush_i      = f;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SEED_WIDTH-1:0] rnd_seed();
    logic [SEED_WIDTH-1:0] s;
    for (int k = 0; k < SEED_WIDTH / 32; k++) s[k*32 +: 32] = $urandom;
    return s;
  endfunction

  initial begin
    logic [SEED_WIDTH-1:0] s;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cycle(0, '0, 0, 0);

    // Known seed, drained back-to-back.
    s = {64'd4, 64'd3, 64'd2, 64'd1};
    cycle(1, s, 0, 0);
    repeat (4) cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);

    // Empty request.
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);

    // Fill to full with valid held, fifth seed waits; full + last-slice pop, 3 rounds.
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int k = 0; k < 5; k++) cycle(1, rnd_seed(), 0, 0);
      s = rnd_seed();
      for (int k = 0; k < 4; k++) cycle(1, s, 1, 0);
      cycle(1, s, 0, 0);
      for (int k = 0; k < DEPTH * SLICES; k++) cycle(0, '0, 1, 0);
      cycle(0, '0, 0, 0);
    end

    // Flush with head at slice 2, colliding with request and offered seed.
    cycle(1, rnd_seed(), 0, 0);
    cycle(1, rnd_seed(), 0, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);
    cycle(1, rnd_seed(), 1, 1);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);

    // Async reset while a response is on the outputs.
    cycle(1, rnd_seed(), 0, 0);
    seed_valid_i = 1'b0;
    req_i = 1'b1;
    @(posedge clk);
    #1 req_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("async_valid", 64'(rsp_valid_o), 64'd0);
    check("async_ok", 64'(rsp_ok_o), 64'd0);
    check("async_data", rsp_data_o, 64'd0);
    check("async_level", 64'(level_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);

    // Randomized traffic.
    for (int k = 0; k < 2000; k++)
      cycle(($urandom_range(0, 1) == 1), rnd_seed(), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 99) < 2));

    repeat (3) cycle(0, '0, 0, 0);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rdseed_buffer.md
# rdseed_buffer

Seed store on the receiving end of the conditioner's RDSEED valid/ready seed interface. Accepts whole 256-bit conditioned seeds, holds up to DEPTH of them, and serves them to the host RDSEED port as 64-bit words, least-significant slice first. Each consumed slice is zeroized. An empty buffer returns a failed response (carry-flag-clear semantics) with zero data; it never stalls.

## Interface
- SEED_WIDTH, 256, width of one seed from the conditioner.
- WORD_WIDTH, 64, width of one RDSEED response; SEED_WIDTH must be an integer multiple of it.
- DEPTH, 4, seed entries stored; power of two, ≥ 2.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- seed_valid_i  in  1  conditioner presents a seed.
- seed_ready_o  out  1  buffer can accept a seed.
- seed_i  in  SEED_WIDTH  seed data, sampled on handshake.
- req_i  in  1  host requests one word this cycle; may be asserted back-to-back.
- flush_i  in  1  discard and zeroize all stored entropy.
- rsp_valid_o  out  1  response for the request one cycle earlier.
- rsp_ok_o  out  1  1 = rsp_data_o holds entropy; 0 = no entropy available.
- rsp_data_o  out  WORD_WIDTH  response word; all-zero when rsp_ok_o = 0.
- level_o  out  $clog2(DEPTH)+1  count of seeds held, including a partially consumed head.

## Operation
- Storage: circular FIFO of DEPTH seeds, with write pointer, read pointer, count and slice index (0 .. SEED_WIDTH/WORD_WIDTH−1). All are cleared on reset.
- Push: occurs when seed_valid_i && seed_ready_o. The seed is written at wr_ptr, wr_ptr increments modulo DEPTH, count increments.
- seed_ready_o = (count < DEPTH), combinational from registered count. There is no pass-through: when full, a pop and a push in the same cycle still refuse the push that cycle.
- Request with count > 0:
  - The response word is head[slice*WORD_WIDTH +: WORD_WIDTH] and rsp_ok = 1.
  - That slice of the head entry is overwritten with zero.
  - slice increments.
  - On the last slice: slice → 0, rd_ptr increments modulo DEPTH, count decrements.
- Request with count = 0: rsp_ok = 0, data = 0, and no state changes. A seed pushed in the same cycle is not visible to that request (no bypass).
- Simultaneous push and last-slice pop: count is unchanged, and both pointers advance.
- Flush has priority over push and request in the same cycle:
  - All entries are zeroed, and pointers, count and slice are cleared.
  - A same-cycle request gets rsp_ok = 0 and data 0.
  - A same-cycle offered seed is not accepted, because seed_ready_o is forced to 0 during flush.
- No state machine beyond the FIFO: the slice counter is the only sub-entry sequencing.

## Timing
- Reset values: seed_ready_o = 1, rsp_valid_o = 0, rsp_ok_o = 0, rsp_data_o = 0, level_o = 0. Handshakes while rst is high are ignored.
- Response latency is exactly 1 cycle: rsp_valid_o/rsp_ok_o/rsp_data_o are registered, so request in cycle N gives response in cycle N+1. One response is produced per request, and requests can be issued every cycle.
- rsp_valid_o is high only in cycles following a request. rsp_data_o returns to 0 and rsp_ok_o to 0 when rsp_valid_o is low.
- level_o and seed_ready_o reflect a push or pop in the cycle after the handshake.
- Throughput:
  - Sustained request rate is one word per cycle while seeds are present.
  - A seed drains in SEED_WIDTH/WORD_WIDTH cycles (4 by default).
  - The fill rate is one seed per cycle.
- Reset mid-operation: asynchronous clear of everything, including stored data (zeroized). Any in-flight response is dropped.

## Test plan
- Reset, then push seed 0x…0004_0003_0002_0001 (64-bit slices 1, 2, 3, 4), then 4 back-to-back requests. Expect 4 responses with rsp_ok = 1, data 1, 2, 3, 4. level_o goes 1 → 0 after the fourth. The entry reads all-zero internally.
- Request with the buffer empty. Expect rsp_valid = 1, rsp_ok = 0, data 0 the next cycle, and level_o stays 0.
- Push 4 seeds with seed_valid_i held high; a fifth waits. Expect seed_ready_o = 0 and level_o = 4. After 4 requests drain one seed, seed_ready_o returns to 1 the next cycle and the fifth is accepted.
- Full buffer, last-slice request and offered push in the same cycle. Expect the push refused that cycle, then accepted next cycle. level_o goes 4 → 3 → 4, and pointers wrap correctly over 3 full fill/drain cycles.
- Two seeds stored with head at slice 2; assert flush_i together with req_i and seed_valid_i. Expect response rsp_ok = 0, data 0, level_o = 0, no seed accepted. A subsequent request returns rsp_ok = 0.
- Assert rst asynchronously between clock edges while a response is pending. Expect all outputs at their reset values immediately. After release, a request returns rsp_ok = 0.
